// File: rtl/ks_voice_allocator.sv
// Polyphonic voice allocator: shares NUM_VOICES Karplus-Strong voices among MIDI
// note events (retrigger same note, else lowest free voice, else steal the oldest).
module ks_voice_slot #(
    parameter int AGE_W = 8
) (
    input  logic             a_clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             load,
    input  logic             bump,
    input  logic [6:0]       load_note,
    output logic             active,
    output logic [6:0]       note,
    output logic [AGE_W-1:0] age
);
    always_ff @(posedge a_clk or negedge reset_n) begin
        if (!reset_n) begin
            active <= 1'b0;
            note   <= '0;
            age    <= '0;
        end else if (load) begin
            active <= 1'b1;
            note   <= load_note;
            age    <= '0;
        end else begin
            if (clr)
                active <= 1'b0;
            // age only advances for sounding voices and saturates
            if (bump && active && (age != {AGE_W{1'b1}}))
                age <= age + 1'b1;
        end
    end
endmodule

module ks_voice_allocator #(
    parameter int NUM_VOICES  = 4,
    parameter int TRIG_CYCLES = 16,
    parameter int AGE_W       = 8
) (
    input  logic                    a_clk,
    input  logic                    reset_n,
    input  logic                    note_valid,
    output logic                    note_ready,
    input  logic                    note_on,
    input  logic [6:0]              note_num,
    output logic [NUM_VOICES-1:0]   voice_active,
    output logic [7*NUM_VOICES-1:0] voice_note,
    output logic [NUM_VOICES-1:0]   voice_trig,
    output logic                    steal,
    output logic                    busy
);
    localparam int IW = $clog2(NUM_VOICES);
    localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, ASSIGN, TRIG} state_t;

    state_t                             state_q, state_nx;
    logic [IW-1:0]                      scan_idx;
    logic                               lat_on;
    logic [6:0]                         lat_note;
    logic                               match_f, free_f, old_f;
    logic [IW-1:0]                      match_i, free_i, old_i, tgt_q, tgt_sel;
    logic [AGE_W-1:0]                   old_age;
    logic [7:0]                         trig_cnt;
    logic                               accept;

    logic [NUM_VOICES-1:0][6:0]         note_arr;
    logic [NUM_VOICES-1:0][AGE_W-1:0]   age;
    logic [NUM_VOICES-1:0]              clr, load, bump;

    logic                               cur_act;
    logic [6:0]                         cur_note;
    logic [AGE_W-1:0]                   cur_age;

    assign accept     = note_valid && note_ready;
    assign busy       = (state_q != IDLE);
    assign voice_note = note_arr;
    assign cur_act    = voice_active[scan_idx];
    assign cur_note   = note_arr[scan_idx];
    assign cur_age    = age[scan_idx];
    assign tgt_sel    = match_f ? match_i : (free_f ? free_i : old_i);
    assign steal      = (state_q == ASSIGN) && !match_f && !free_f;

    genvar v;
    generate
        for (v = 0; v < NUM_VOICES; v++) begin : g_slot
            assign clr[v]  = (state_q == SCAN) && !lat_on && (scan_idx == IW'(v))
                             && voice_active[v] && (note_arr[v] == lat_note);
            assign load[v] = (state_q == ASSIGN) && (tgt_sel == IW'(v));
            assign bump[v] = (state_q == ASSIGN) && (tgt_sel != IW'(v));
            assign voice_trig[v] = (state_q == TRIG) && (tgt_q == IW'(v));

            ks_voice_slot #(.AGE_W(AGE_W)) u_slot (
                .a_clk    (a_clk),
                .reset_n  (reset_n),
                .clr      (clr[v]),
                .load     (load[v]),
                .bump     (bump[v]),
                .load_note(lat_note),
                .active   (voice_active[v]),
                .note     (note_arr[v]),
                .age      (age[v])
            );
        end
    endgenerate

    always_ff @(posedge a_clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            IDLE:   if (accept) state_nx = SCAN;
            SCAN:   if (scan_idx == LAST) state_nx = lat_on ? ASSIGN : IDLE;
            ASSIGN: state_nx = TRIG;
            TRIG:   if (trig_cnt == 8'(TRIG_CYCLES - 1)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge a_clk or negedge reset_n) begin
        if (!reset_n) begin
            note_ready <= 1'b0;
            scan_idx   <= '0;
            lat_on     <= 1'b0;
            lat_note   <= '0;
            match_f    <= 1'b0;
            free_f     <= 1'b0;
            old_f      <= 1'b0;
            match_i    <= '0;
            free_i     <= '0;
            old_i      <= '0;
            old_age    <= '0;
            tgt_q      <= '0;
            trig_cnt   <= '0;
        end else begin
            // ready is registered so it tracks the state being entered
            note_ready <= (state_nx == IDLE);
            case (state_q)
                IDLE: if (accept) begin
                    lat_on   <= note_on;
                    lat_note <= note_num;
                    scan_idx <= '0;
                    match_f  <= 1'b0;
                    free_f   <= 1'b0;
                    old_f    <= 1'b0;
                end
                SCAN: begin
                    scan_idx <= scan_idx + 1'b1;
                    if (cur_act && (cur_note == lat_note) && !match_f) begin
                        match_f <= 1'b1;
                        match_i <= scan_idx;
                    end
                    if (!cur_act && !free_f) begin
                        free_f <= 1'b1;
                        free_i <= scan_idx;
                    end
                    // strict compare keeps ties on the lowest index
                    if (cur_act && (!old_f || (cur_age > old_age))) begin
                        old_f   <= 1'b1;
                        old_i   <= scan_idx;
                        old_age <= cur_age;
                    end
                end
                ASSIGN: begin
                    tgt_q    <= tgt_sel;
                    trig_cnt <= '0;
                end
                TRIG: trig_cnt <= trig_cnt + 1'b1;
                default: ;
            endcase
        end
    end
endmodule
